fetch_sequencer: RTL and testbench

Instruction sequencer for the TP2 processor. It holds the program counter and fetches 22-bit instruction words from program memory. It presents each word to the microinstruction ROM and generates that ROM's HOLD so that each instruction is decoded exactly once. It also resolves jumps, calls and returns through a small return stack, and stalls on data-memory accesses until they are acknowledged.

---
 rtl/tp2_pkg.sv | 39 +++
 rtl/fetch_sequencer_if.sv | 46 ++++
 rtl/fetch_sequencer_return_stack.sv | 52 +++++
 rtl/fetch_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tp2_pkg.sv
// ---------------------------------------------------------------------------
// tp2_pkg
// Shared definitions for the TP2 instruction sequencer and the
// microinstruction ROM: sequencer state encoding, opcode compare constants
// and the default program-counter / instruction widths.
// No ports (package).
// ---------------------------------------------------------------------------
package tp2_pkg;

    localparam int DEF_PC_W = 11;
    localparam int DEF_IR_W = 22;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM_WAIT = 3'd4
    } state_e;

    // Jumps compare instruction[21:11]; the low 11 bits are the target.
    localparam logic [10:0] OP_JUMP = 11'b100_0000_0000;
    localparam logic [10:0] OP_JZE  = 11'b101_0000_0000;
    localparam logic [10:0] OP_JNE  = 11'b110_0000_0000;
    localparam logic [10:0] OP_JCY  = 11'b111_0000_0000;

    // BSR and the memory moves compare instruction[21:10].
    localparam logic [11:0] OP_BSR  = 12'b0111_0000_0000;
    localparam logic [11:0] OP_MOMW = 12'b0100_0000_0000;  // MOM Y,W : M(y)=W
    localparam logic [11:0] OP_MOMR = 12'b0101_0000_0000;  // MOM W,Y : W=M(y)

    // RET is matched on the whole word.
    localparam logic [21:0] OP_RET  = 22'h06_0000;

    function automatic logic is_mom(input logic [21:0] word);
        return (word[21:10] == OP_MOMW) || (word[21:10] == OP_MOMR);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bus bundle between the sequencer and its two memories.
//   prog_addr  program memory address (sequencer -> program memory)
//   prog_rd    program memory read strobe
//   prog_data  program memory read data, valid the cycle after prog_rd
//   mem_req    data-memory access request
//   mem_we     1 = write (M(y)=W), 0 = read (W=M(y)); meaningful with mem_req
//   mem_ack    data-memory completion
//
// Handshake: mem_req rises with the instruction's EXEC cycle and stays high,
// with mem_we stable, until a rising clock edge sees mem_ack=1; that edge
// completes the access. mem_ack is a same-cycle acknowledge (no extra
// latency) and is ignored whenever mem_req is low.
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int PC_W = tp2_pkg::DEF_PC_W,
    parameter int IR_W = tp2_pkg::DEF_IR_W
) ();

    logic [PC_W-1:0] prog_addr;
    logic            prog_rd;
    logic [IR_W-1:0] prog_data;
    logic            mem_req;
    logic            mem_we;
    logic            mem_ack;

    modport master (
        output prog_addr,
        output prog_rd,
        input  prog_data,
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  prog_addr,
        input  prog_rd,
        output prog_data,
        input  mem_req,
        input  mem_we,
        output mem_ack
    );

endinterface

// File: rtl/fetch_sequencer_return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
// LIFO of return addresses for BSR/RET.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write data_in on top (ignored when full)
//   pop         drop the top entry (ignored when empty)
//   data_in     address to push
//   data_out    current top entry (undefined content when empty)
//   full        DEPTH entries present
//   empty       no entries present
// ---------------------------------------------------------------------------
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  entries [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] top;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign top      = count - 1'b1;
    assign data_out = entries[top[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[count[AW-1:0]] <= data_in;
            count                  <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// TP2 instruction sequencer: holds the PC, fetches instruction words,
// presents them to the microinstruction ROM with a one-cycle HOLD=0 window,
// resolves jumps / BSR / RET and stalls on data-memory moves.
//   clk          system clock
//   RST_N        asynchronous active-low reset
//   run          execution enable (sampled in IDLE and when an instruction ends)
//   ZE, CY       datapath flags, sampled on the edge ending EXEC
//   instruction  instruction register to the MI ROM
//   HOLD         ROM freeze, low only in EXEC
//   stack_err    sticky return-stack overflow/underflow
//   state_dbg    current FSM state (tp2_pkg::state_e encoding)
//   bus          program memory and data memory signals (master side)
// ---------------------------------------------------------------------------
module fetch_sequencer
    import tp2_pkg::*;
#(
    parameter int              PC_W        = DEF_PC_W,
    parameter int              IR_W        = DEF_IR_W,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              run,
    input  logic              ZE,
    input  logic              CY,
    output logic [IR_W-1:0]   instruction,
    output logic              HOLD,
    output logic              stack_err,
    output logic [2:0]        state_dbg,
    fetch_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_FETCH    = ST_FETCH;
    localparam logic [2:0] S_LOAD     = ST_LOAD;
    localparam logic [2:0] S_EXEC     = ST_EXEC;
    localparam logic [2:0] S_MEM_WAIT = ST_MEM_WAIT;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;

    // Decode of the instruction register
    logic [10:0]     op11;
    logic [11:0]     op12;
    logic            is_jump;
    logic            is_jze;
    logic            is_jne;
    logic            is_jcy;
    logic            is_bsr;
    logic            is_ret;
    logic            is_mem;
    logic            jump_taken;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] bsr_target;

    // Return stack control
    logic            push;
    logic            pop;
    logic            err_set;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

    assign op11        = instruction[21:11];
    assign op12        = instruction[21:10];
    assign is_jump     = (op11 == OP_JUMP);
    assign is_jze      = (op11 == OP_JZE);
    assign is_jne      = (op11 == OP_JNE);
    assign is_jcy      = (op11 == OP_JCY);
    assign is_bsr      = (op12 == OP_BSR);
    assign is_ret      = (instruction[21:0] == OP_RET);
    assign is_mem      = is_mom(instruction[21:0]);
    assign jump_taken  = is_jump | (is_jze & ZE) | (is_jne & ~ZE) | (is_jcy & CY);
    assign jump_target = PC_W'(instruction[10:0]);
    // BSR can only reach the lower half of program space.
    assign bsr_target  = PC_W'({1'b0, instruction[9:0]});
    assign pc_inc      = pc + PC_W'(1);

    // Moore outputs
    assign bus.prog_addr = pc;
    assign bus.prog_rd   = (state == S_FETCH);
    assign HOLD          = (state != S_EXEC);
    assign bus.mem_req   = ((state == S_EXEC) && is_mem) || (state == S_MEM_WAIT);
    assign bus.mem_we    = bus.mem_req && (op12 == OP_MOMW);
    assign state_dbg     = state;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_return_stack (
        .clk      (clk),
        .rst_n    (RST_N),
        .push     (push),
        .pop      (pop),
        .data_in  (pc_inc),
        .data_out (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = run ? S_FETCH : S_IDLE;
            S_FETCH:    state_nxt = S_LOAD;
            S_LOAD:     state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_mem && !bus.mem_ack) begin
                    state_nxt = S_MEM_WAIT;
                end else begin
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // The PC is resolved in the single EXEC cycle; a memory move advances it
    // there too, since the stall only delays the next FETCH.
    always_comb begin
        pc_nxt  = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (state == S_EXEC) begin
            if (jump_taken) begin
                pc_nxt = jump_target;
            end else if (is_bsr) begin
                // Overflow still jumps; the return address is lost.
                pc_nxt  = bsr_target;
                push    = ~stk_full;
                err_set = stk_full;
            end else if (is_ret) begin
                if (stk_empty) begin
                    pc_nxt  = RESET_PC;
                    err_set = 1'b1;
                end else begin
                    pc_nxt = stk_top;
                    pop    = 1'b1;
                end
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            stack_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_LOAD) begin
                instruction <= bus.prog_data;
            end
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import tp2_pkg::*;

    localparam int PC_W = 11;
    localparam int IR_W = 22;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            RST_N;
    logic            run;
    logic            ZE;
    logic            CY;
    logic [IR_W-1:0] instruction;
    logic            HOLD;
    logic            stack_err;
    logic [2:0]      state_dbg;

    fetch_sequencer_if #(.PC_W(PC_W), .IR_W(IR_W)) bus ();

    fetch_sequencer #(
        .PC_W        (PC_W),
        .IR_W        (IR_W),
        .STACK_DEPTH (4),
        .RESET_PC    ('0)
    ) dut (
        .clk         (clk),
        .RST_N       (RST_N),
        .run         (run),
        .ZE          (ZE),
        .CY          (CY),
        .instruction (instruction),
        .HOLD        (HOLD),
        .stack_err   (stack_err),
        .state_dbg   (state_dbg),
        .bus         (bus)
    );

    // Program memory: read data follows the address, so it is valid in LOAD.
    logic [IR_W-1:0] mem [0:2047];
    assign bus.prog_data = mem[bus.prog_addr];

    // ---------------- scoreboard state ----------------
    logic [PC_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    bit strict = 1'b0;
    int ack_delay = 0;
    int ack_cnt = 0;
    int req_cnt, we_cnt, mw_cnt, mw_hold_cnt, req_exec_cnt;
    bit prev_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [PC_W-1:0] e;
        forever begin
            @(negedge clk);
            if (RST_N !== 1'b1) begin
                prev_low = 1'b0;
            end else begin
                if (bus.prog_rd === 1'b1) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("fetch_addr", 32'(bus.prog_addr), 32'(e));
                    end else if (strict) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: got 0x%0h expected none", bus.prog_addr);
                    end
                end
                if (HOLD === 1'b0) begin
                    check("exec_instr", 32'(instruction), 32'(mem[bus.prog_addr]));
                    check("hold_pulse_len", 32'(prev_low), 32'(0));
                end
                prev_low = (HOLD === 1'b0);
                if (bus.mem_req === 1'b1) req_cnt++;
                if (bus.mem_we === 1'b1) we_cnt++;
                if (state_dbg == ST_MEM_WAIT) mw_cnt++;
                if (state_dbg == ST_MEM_WAIT && HOLD === 1'b1) mw_hold_cnt++;
                if (bus.mem_req === 1'b1 && HOLD === 1'b0) req_exec_cnt++;
            end
        end
    end

    // ---------------- data-memory responder ----------------
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                bus.mem_ack = (ack_cnt >= ack_delay);
                ack_cnt++;
            end else begin
                bus.mem_ack = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup();
        step();
        RST_N = 1'b0;
        run = 1'b0;
        ZE = 1'b0;
        CY = 1'b0;
        ack_delay = 0;
        strict = 1'b0;
        exp_q.delete();
        #1;
        check("rst_prog_addr", 32'(bus.prog_addr), 32'(0));
        check("rst_prog_rd", 32'(bus.prog_rd), 32'(0));
        check("rst_hold", 32'(HOLD), 32'(1));
        check("rst_mem_req", 32'(bus.mem_req), 32'(0));
        check("rst_mem_we", 32'(bus.mem_we), 32'(0));
        check("rst_instruction", 32'(instruction), 32'(0));
        check("rst_stack_err", 32'(stack_err), 32'(0));
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        for (int i = 0; i < 2048; i++) mem[i] = IR_W'(i);
        req_cnt = 0; we_cnt = 0; mw_cnt = 0; mw_hold_cnt = 0; req_exec_cnt = 0;
    endtask

    task automatic go();
        step();
        RST_N = 1'b1;
        run = 1'b1;
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int i = 0;
        while (exp_q.size() > n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(name, 32'(exp_q.size()), 32'(n));
    endtask

    task automatic push_exp(input logic [PC_W-1:0] a);
        exp_q.push_back(a);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int rd_n, hl_n;
        RST_N = 1'b0;
        run = 1'b0;
        ZE = 1'b0;
        CY = 1'b0;

        // Sequential words: 3-cycle instructions, one HOLD-low cycle each.
        setup();
        push_exp(0); push_exp(1); push_exp(2);
        go();
        step();
        rd_n = 0; hl_n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) check("first_fetch", 32'(bus.prog_rd), 32'(1));
            if (bus.prog_rd === 1'b1) rd_n++;
            if (HOLD === 1'b0) hl_n++;
        end
        check("seq_fetch_count", 32'(rd_n), 32'(3));
        check("seq_hold_low_count", 32'(hl_n), 32'(3));
        wait_q(0, 30, "seq_drain");

        // Jumps with ZE=0, CY=0
        setup();
        mem[0] = 22'h200005; mem[5] = 22'h280009; mem[6] = 22'h300014;
        mem[9] = 22'h300014; mem[10] = 22'h380030; mem[11'h14] = 22'h380030;
        push_exp(0); push_exp(5); push_exp(6); push_exp(11'h14); push_exp(11'h15);
        go();
        wait_q(0, 40, "jump_flags0_drain");

        // Jumps with ZE=1, CY=1
        setup();
        mem[0] = 22'h200005; mem[5] = 22'h280009; mem[6] = 22'h300014;
        mem[9] = 22'h300014; mem[10] = 22'h380030; mem[11'h14] = 22'h380030;
        ZE = 1'b1; CY = 1'b1;
        push_exp(0); push_exp(5); push_exp(9); push_exp(10); push_exp(11'h30); push_exp(11'h31);
        go();
        wait_q(0, 40, "jump_flags1_drain");

        // BSR / RET, then RET on the emptied stack underflows to 0
        setup();
        mem[3] = 22'h1C0010; mem[11'h10] = 22'h060000; mem[5] = 22'h060000;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(11'h10);
        push_exp(4); push_exp(5); push_exp(0);
        go();
        wait_q(1, 60, "bsr_ret_reach5");
        check("bsr_ret_no_err", 32'(stack_err), 32'(0));
        wait_q(0, 20, "underflow_drain");
        check("underflow_err", 32'(stack_err), 32'(1));

        // Five nested BSRs overflow; the fifth return address is dropped
        setup();
        mem[0] = 22'h1C0100; mem[11'h100] = 22'h1C0200; mem[11'h200] = 22'h1C0300;
        mem[11'h300] = 22'h1C0080; mem[11'h080] = 22'h1C0180; mem[11'h180] = 22'h060000;
        push_exp(0); push_exp(11'h100); push_exp(11'h200); push_exp(11'h300);
        push_exp(11'h080); push_exp(11'h180); push_exp(11'h301);
        go();
        wait_q(2, 40, "nest_reach4");
        check("nest4_no_err", 32'(stack_err), 32'(0));
        wait_q(0, 30, "nest_drain");
        check("overflow_err", 32'(stack_err), 32'(1));

        // MOM Y,W with acknowledge 4 cycles late
        setup();
        mem[0] = 22'h100000;
        ack_delay = 4;
        push_exp(0); push_exp(1); push_exp(2);
        go();
        wait_q(0, 40, "momw_slow_drain");
        check("momw_slow_req", 32'(req_cnt), 32'(5));
        check("momw_slow_we", 32'(we_cnt), 32'(5));
        check("momw_slow_wait", 32'(mw_cnt), 32'(4));
        check("momw_slow_hold", 32'(mw_hold_cnt), 32'(4));
        check("momw_slow_req_exec", 32'(req_exec_cnt), 32'(1));

        // MOM Y,W acknowledged in the EXEC cycle
        setup();
        mem[0] = 22'h100000;
        push_exp(0); push_exp(1); push_exp(2);
        go();
        wait_q(0, 30, "momw_fast_drain");
        check("momw_fast_req", 32'(req_cnt), 32'(1));
        check("momw_fast_we", 32'(we_cnt), 32'(1));
        check("momw_fast_wait", 32'(mw_cnt), 32'(0));

        // MOM W,Y with acknowledge 2 cycles late
        setup();
        mem[0] = 22'h140000;
        ack_delay = 2;
        push_exp(0); push_exp(1); push_exp(2);
        go();
        wait_q(0, 30, "momr_drain");
        check("momr_req", 32'(req_cnt), 32'(3));
        check("momr_we", 32'(we_cnt), 32'(0));
        check("momr_wait", 32'(mw_cnt), 32'(2));

        // PC wrap on increment
        setup();
        mem[0] = 22'h2007FF;
        push_exp(0); push_exp(11'h7FF); push_exp(0);
        go();
        wait_q(0, 30, "wrap_drain");

        // Pushed return address wraps too
        setup();
        mem[0] = 22'h2007FF; mem[11'h7FF] = 22'h1C0010; mem[11'h10] = 22'h060000;
        push_exp(0); push_exp(11'h7FF); push_exp(11'h10); push_exp(0);
        go();
        wait_q(0, 30, "wrap_ret_drain");
        check("wrap_ret_no_err", 32'(stack_err), 32'(0));

        // Reset during MEM_WAIT
        setup();
        mem[0] = 22'h100000;
        ack_delay = 100;
        push_exp(0);
        go();
        wait_q(0, 20, "mw_rst_fetch");
        for (int i = 0; i < 20 && state_dbg != ST_MEM_WAIT; i++) @(negedge clk);
        check("mw_rst_reached", 32'(state_dbg), 32'(ST_MEM_WAIT));
        step();
        check("mw_rst_pre_req", 32'(bus.mem_req), 32'(1));
        check("mw_rst_pre_pc", 32'(bus.prog_addr), 32'(1));
        RST_N = 1'b0;
        #1;
        check("mw_rst_req", 32'(bus.mem_req), 32'(0));
        check("mw_rst_we", 32'(bus.mem_we), 32'(0));
        check("mw_rst_hold", 32'(HOLD), 32'(1));
        check("mw_rst_pc", 32'(bus.prog_addr), 32'(0));
        check("mw_rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // run dropped mid-program: current instruction finishes, then IDLE
        setup();
        strict = 1'b1;
        push_exp(0); push_exp(1);
        go();
        wait_q(0, 20, "stop_drain");
        step();
        run = 1'b0;
        repeat (8) @(negedge clk);
        check("stop_state", 32'(state_dbg), 32'(ST_IDLE));
        check("stop_hold", 32'(HOLD), 32'(1));
        check("stop_pc", 32'(bus.prog_addr), 32'(2));
        check("stop_instr", 32'(instruction), 32'(1));
        strict = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
